// File: rtl/fpu_issue_ctrl_pkg.sv
// Shared FP issue definitions: opcodes, state encoding and decode helpers
// for the decode and EX stages.
package fpu_issue_ctrl_pkg;

  localparam int unsigned OP_W   = 4;
  localparam int unsigned DATA_W = 32;

  localparam logic [OP_W-1:0] FOP_ITOF = 4'b1000;
  localparam logic [OP_W-1:0] FOP_FTOI = 4'b1001;
  localparam logic [OP_W-1:0] FOP_FNEG = 4'b1010;
  localparam logic [OP_W-1:0] FOP_FADD = 4'b1011;
  localparam logic [OP_W-1:0] FOP_FSUB = 4'b1100;
  localparam logic [OP_W-1:0] FOP_FMUL = 4'b1101;
  localparam logic [OP_W-1:0] FOP_FDIV = 4'b1110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } fpu_state_e;

  // Ops that go through a pipelined unit and therefore stall EX.
  function automatic logic is_multi_cycle(input logic [OP_W-1:0] op);
    return op inside {FOP_FADD, FOP_FSUB, FOP_FMUL, FOP_FDIV};
  endfunction

endpackage

// File: rtl/fpu_issue_ctrl_if.sv
// EX-side handshake plus the operand/result bus to the FP units.
interface fpu_issue_ctrl_if;
  import fpu_issue_ctrl_pkg::*;

  logic              issue;
  logic [OP_W-1:0]   op;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              flush;
  logic              stall;
  logic              done;
  logic [DATA_W-1:0] result;
  logic              illegal;
  logic              div_zero;
  logic [DATA_W-1:0] fu_a;
  logic [DATA_W-1:0] fu_b;
  logic              fu_add_sub;
  logic [DATA_W-1:0] addsub_res;
  logic [DATA_W-1:0] mul_res;
  logic [DATA_W-1:0] div_res;
  logic              div_by_zero;

  modport master (
    output issue, op, a, b, flush, addsub_res, mul_res, div_res, div_by_zero,
    input  stall, done, result, illegal, div_zero, fu_a, fu_b, fu_add_sub
  );

  modport slave (
    input  issue, op, a, b, flush, addsub_res, mul_res, div_res, div_by_zero,
    output stall, done, result, illegal, div_zero, fu_a, fu_b, fu_add_sub
  );

endinterface

// File: rtl/fpu_lat_counter.sv
// Latency down-counter: load, decrement to zero and clear, with a zero flag.
module fpu_lat_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  input  logic             clear,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/fpu_issue_ctrl.sv
// FP issue controller: registers operands, times unit latency with a
// down-counter, stalls EX and returns one registered result per op.
module fpu_issue_ctrl
  import fpu_issue_ctrl_pkg::*;
#(
  parameter int unsigned LAT_ADDSUB = 7,
  parameter int unsigned LAT_MUL    = 6,
  parameter int unsigned LAT_DIV    = 6,
  parameter int unsigned CNT_W      = 4
) (
  input  logic            clk,
  input  logic            rst,
  fpu_issue_ctrl_if.slave bus
);

  fpu_state_e        state;
  logic [OP_W-1:0]   op_q;
  logic              done_q;
  logic [DATA_W-1:0] result_q;
  logic              illegal_q;
  logic              div_zero_q;
  logic [DATA_W-1:0] fu_a_q;
  logic [DATA_W-1:0] fu_b_q;
  logic              fu_add_sub_q;

  logic              idle_or_done;
  logic              accept;
  logic              multi;
  logic              cnt_zero;
  logic              cnt_load;
  logic              cnt_dec;
  logic              cnt_clear;
  logic [CNT_W-1:0]  lat_sel;
  logic [DATA_W-1:0] unit_res;

  assign idle_or_done = (state == ST_IDLE) || (state == ST_DONE);
  assign multi        = is_multi_cycle(bus.op);
  assign accept       = idle_or_done && bus.issue && !bus.flush;

  assign bus.stall = (state == ST_BUSY) || (idle_or_done && bus.issue && multi);

  // Latency for the op being accepted.
  always_comb begin
    lat_sel = CNT_W'(LAT_ADDSUB);
    case (bus.op)
      FOP_FMUL: lat_sel = CNT_W'(LAT_MUL);
      FOP_FDIV: lat_sel = CNT_W'(LAT_DIV);
      default:  lat_sel = CNT_W'(LAT_ADDSUB);
    endcase
  end

  // Unit output selected by the op in flight.
  always_comb begin
    unit_res = bus.addsub_res;
    case (op_q)
      FOP_FMUL: unit_res = bus.mul_res;
      FOP_FDIV: unit_res = bus.div_res;
      default:  unit_res = bus.addsub_res;
    endcase
  end

  assign cnt_load  = accept && multi;
  assign cnt_dec   = (state == ST_BUSY) && !cnt_zero;
  assign cnt_clear = (state == ST_BUSY) && (bus.flush || cnt_zero);

  fpu_lat_counter #(.CNT_W(CNT_W)) u_lat_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (lat_sel),
    .dec      (cnt_dec),
    .clear    (cnt_clear),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      op_q         <= '0;
      done_q       <= 1'b0;
      result_q     <= '0;
      illegal_q    <= 1'b0;
      div_zero_q   <= 1'b0;
      fu_a_q       <= '0;
      fu_b_q       <= '0;
      fu_add_sub_q <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_BUSY: begin
          if (bus.flush) begin
            state <= ST_IDLE;
          end else if (cnt_zero) begin
            state      <= ST_DONE;
            done_q     <= 1'b1;
            result_q   <= unit_res;
            div_zero_q <= (op_q == FOP_FDIV) && bus.div_by_zero;
          end
        end
        default: begin
          if (accept) begin
            fu_a_q    <= bus.a;
            fu_b_q    <= bus.b;
            op_q      <= bus.op;
            illegal_q <= 1'b0;
            if (bus.op == FOP_FADD) fu_add_sub_q <= 1'b1;
            else if (bus.op == FOP_FSUB) fu_add_sub_q <= 1'b0;
            if (multi) begin
              state <= ST_BUSY;
            end else begin
              // fneg and illegal ops complete on the accept edge.
              state      <= ST_DONE;
              done_q     <= 1'b1;
              div_zero_q <= 1'b0;
              if (bus.op == FOP_FNEG) begin
                result_q <= {~bus.a[31], bus.a[30:0]};
              end else begin
                result_q  <= '0;
                illegal_q <= 1'b1;
              end
            end
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.done       = done_q;
  assign bus.result     = result_q;
  assign bus.illegal    = illegal_q;
  assign bus.div_zero   = div_zero_q;
  assign bus.fu_a       = fu_a_q;
  assign bus.fu_b       = fu_b_q;
  assign bus.fu_add_sub = fu_add_sub_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl: latency/stall timing, result selection,
// fneg/illegal fast path, flush and mid-op reset.
module tb_fpu_issue_ctrl;
  import fpu_issue_ctrl_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   n_busy;
  int   n_done;

  fpu_issue_ctrl_if bus ();

  fpu_issue_ctrl #(
    .LAT_ADDSUB (7),
    .LAT_MUL    (6),
    .LAT_DIV    (6),
    .CNT_W      (4)
  ) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts stall cycles until done rises; stops at done (posedge+1 phase).
  task automatic wait_done(input string tag, output int n);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.done) return;
      if (bus.stall) n++;
      tick();
    end
    check({tag, "_timeout"}, 32'(bus.done), 32'd1);
  endtask

  // Present an op for one cycle; checks stall in the issue cycle.
  task automatic issue_op(input string tag, input logic [3:0] o,
                          input logic [31:0] x, input logic [31:0] y,
                          input logic exp_stall);
    bus.issue = 1'b1;
    bus.op    = o;
    bus.a     = x;
    bus.b     = y;
    #1;
    check({tag, "_issue_stall"}, 32'(bus.stall), 32'(exp_stall));
    tick();
    bus.issue = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.issue = 1'b0;
    bus.op    = '0;
    bus.a     = '0;
    bus.b     = '0;
    bus.flush = 1'b0;
    bus.addsub_res  = 32'h40400000;
    bus.mul_res     = 32'h40C00000;
    bus.div_res     = 32'h7F800000;
    bus.div_by_zero = 1'b1;

    // Reset state
    tick();
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", bus.result, 32'h0);
    check("rst_illegal", 32'(bus.illegal), 32'd0);
    check("rst_div_zero", 32'(bus.div_zero), 32'd0);
    check("rst_fu_a", bus.fu_a, 32'h0);
    check("rst_fu_b", bus.fu_b, 32'h0);
    check("rst_fu_add_sub", 32'(bus.fu_add_sub), 32'd1);
    check("rst_stall", 32'(bus.stall), 32'd0);
    bus.issue = 1'b1;
    bus.op    = FOP_FADD;
    #1;
    check("rst_stall_issue", 32'(bus.stall), 32'd1);
    bus.issue = 1'b0;
    rst_n = 1'b1;
    tick();

    // fadd 1.0 + 2.0: 9 stall cycles total, then done with 3.0
    issue_op("fadd", FOP_FADD, 32'h3F800000, 32'h40000000, 1'b1);
    check("fadd_fu_a", bus.fu_a, 32'h3F800000);
    check("fadd_fu_b", bus.fu_b, 32'h40000000);
    check("fadd_fu_add_sub", 32'(bus.fu_add_sub), 32'd1);
    wait_done("fadd", n_busy);
    check("fadd_busy_stall", 32'(n_busy), 32'd8);
    check("fadd_done", 32'(bus.done), 32'd1);
    check("fadd_result", bus.result, 32'h40400000);
    check("fadd_div_zero", 32'(bus.div_zero), 32'd0);
    check("fadd_illegal", 32'(bus.illegal), 32'd0);
    tick();
    check("fadd_done_pulse", 32'(bus.done), 32'd0);

    // fdiv by zero, then fmul issued in the DONE cycle
    issue_op("fdiv", FOP_FDIV, 32'h3F800000, 32'h00000000, 1'b1);
    wait_done("fdiv", n_busy);
    check("fdiv_busy_stall", 32'(n_busy), 32'd7);
    check("fdiv_result", bus.result, 32'h7F800000);
    check("fdiv_div_zero", 32'(bus.div_zero), 32'd1);
    issue_op("fmul", FOP_FMUL, 32'h40000000, 32'h40400000, 1'b1);
    check("fmul_b2b_fu_a", bus.fu_a, 32'h40000000);
    check("fmul_b2b_fu_b", bus.fu_b, 32'h40400000);
    check("fmul_div_zero_hold", 32'(bus.div_zero), 32'd1);
    wait_done("fmul", n_busy);
    check("fmul_busy_stall", 32'(n_busy), 32'd7);
    check("fmul_result", bus.result, 32'h40C00000);
    check("fmul_div_zero", 32'(bus.div_zero), 32'd0);
    tick();

    // fneg: no stall, done next cycle
    issue_op("fneg", FOP_FNEG, 32'h3F800000, 32'h0, 1'b0);
    check("fneg_done", 32'(bus.done), 32'd1);
    check("fneg_result", bus.result, 32'hBF800000);
    check("fneg_stall", 32'(bus.stall), 32'd0);
    tick();

    // fsub with reset pulsed mid-BUSY
    bus.addsub_res = 32'h40000000;
    issue_op("fsub_rst", FOP_FSUB, 32'h40400000, 32'h3F800000, 1'b1);
    check("fsub_fu_add_sub", 32'(bus.fu_add_sub), 32'd0);
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_stall", 32'(bus.stall), 32'd0);
    check("midrst_result", bus.result, 32'h0);
    check("midrst_fu_a", bus.fu_a, 32'h0);
    check("midrst_fu_add_sub", 32'(bus.fu_add_sub), 32'd1);
    tick();
    rst_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.done) n_done++;
    end
    check("midrst_no_done", 32'(n_done), 32'd0);

    // fsub 3.0 - 1.0 after reset
    issue_op("fsub", FOP_FSUB, 32'h40400000, 32'h3F800000, 1'b1);
    wait_done("fsub", n_busy);
    check("fsub_busy_stall", 32'(n_busy), 32'd8);
    check("fsub_result", bus.result, 32'h40000000);
    // flush in DONE blocks the new issue but done still shows
    bus.issue = 1'b1;
    bus.op    = FOP_FADD;
    bus.a     = 32'h11111111;
    bus.flush = 1'b1;
    #1;
    check("done_flush_done", 32'(bus.done), 32'd1);
    tick();
    bus.issue = 1'b0;
    bus.flush = 1'b0;
    #1;
    check("done_flush_fu_a", bus.fu_a, 32'h40400000);
    check("done_flush_stall", 32'(bus.stall), 32'd0);
    check("done_flush_no_done", 32'(bus.done), 32'd0);

    // Illegal opcode (itof)
    issue_op("illegal", FOP_ITOF, 32'h3F800000, 32'h0, 1'b0);
    check("illegal_done", 32'(bus.done), 32'd1);
    check("illegal_flag", 32'(bus.illegal), 32'd1);
    check("illegal_result", bus.result, 32'h0);
    tick();
    check("illegal_hold", 32'(bus.illegal), 32'd1);

    // fmul flushed on its 3rd BUSY cycle
    issue_op("fmul_flush", FOP_FMUL, 32'h40000000, 32'h40400000, 1'b1);
    check("flush_illegal_clr", 32'(bus.illegal), 32'd0);
    check("flush_fu_add_sub_keep", 32'(bus.fu_add_sub), 32'd0);
    tick();
    tick();
    bus.flush = 1'b1;
    #1;
    check("flush_cycle_stall", 32'(bus.stall), 32'd1);
    tick();
    bus.flush = 1'b0;
    #1;
    check("flush_idle_stall", 32'(bus.stall), 32'd0);
    n_done = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.done) n_done++;
      tick();
    end
    check("flush_no_done", 32'(n_done), 32'd0);
    check("flush_result_keep", bus.result, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
